cheri_tsmap_painter: RTL and testbench

- Write-side engine for the temporal-safety map (TSMAP), one bit per 8-byte heap granule; the revocation check stage reads these bits.
- Accepts a range request (base, length, set/clear) from the allocator MMIO/CSR interface.
- Walks every TSMAP word the range covers and issues one masked write per word.
- Shares the TSMAP SRAM port with the reader through an external arbiter.

---
 rtl/cheri_pkg.sv | 15 +
 rtl/cheri_tsmap_mask_gen.sv | 23 ++
 rtl/cheri_tsmap_painter.sv | 148 ++++++++++++++
 tb/tb_cheri_tsmap_painter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cheri_pkg.sv
// Shared CHERI temporal-safety constants and types used by the TSMAP painter
// and by the revocation check stage that reads the same map.
package cheri_pkg;

    localparam int unsigned TSMAP_GRAN_SHIFT = 3;
    localparam int unsigned TSMAP_WORD_SHIFT = 5;

    typedef enum logic [1:0] {
        IDLE,
        CHK,
        WR,
        RESP
    } tsmap_paint_state_e;

endpackage

// File: rtl/cheri_tsmap_mask_gen.sv
// Per-word bit mask for a granule range: the first word starts at bs,
// the last word stops at be, and interior words are fully enabled.
module cheri_tsmap_mask_gen
    import cheri_pkg::*;
(
    input  logic                        first_i,
    input  logic                        last_i,
    input  logic [TSMAP_WORD_SHIFT-1:0] bs_i,
    input  logic [TSMAP_WORD_SHIFT-1:0] be_i,
    output logic [31:0]                 mask_o
);

    logic [TSMAP_WORD_SHIFT-1:0] lo;
    logic [TSMAP_WORD_SHIFT-1:0] hi;

    always_comb begin
        lo     = first_i ? bs_i : '0;
        hi     = last_i  ? be_i : '1;
        // Ones from bit lo upward, intersected with ones from bit hi downward.
        mask_o = (32'hFFFF_FFFF << lo) & (32'hFFFF_FFFF >> (5'd31 - hi));
    end

endmodule

// File: rtl/cheri_tsmap_painter.sv
// TSMAP write engine: validates a byte range, then paints one masked write
// per covered map word through the shared, arbitrated SRAM port.
module cheri_tsmap_painter
    import cheri_pkg::*;
#(
    parameter logic [31:0] HeapBase  = 32'h8000_0000,
    parameter int unsigned TSMapSize = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_base_i,
    input  logic [31:0] req_len_i,
    input  logic        req_set_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic        tsmap_cs_o,
    output logic        tsmap_we_o,
    output logic [15:0] tsmap_addr_o,
    output logic [31:0] tsmap_wdata_o,
    output logic [31:0] tsmap_bmask_o,
    input  logic        tsmap_gnt_i
);

    localparam int unsigned GW = 32 - TSMAP_GRAN_SHIFT;
    localparam int unsigned WW = GW - TSMAP_WORD_SHIFT;
    localparam int unsigned IW = 33 - TSMAP_WORD_SHIFT;
    localparam logic [IW-1:0] MapWords = IW'(TSMapSize);

    tsmap_paint_state_e state_q, state_d;

    logic [31:0]                 base_q, len_q;
    logic                        set_q, err_q;
    logic [15:0]                 ws_q, we_q, cur_q;
    logic [TSMAP_WORD_SHIFT-1:0] bs_q, be_q;

    logic [GW-1:0] gs, len_gran;
    logic [32:0]   end_sum, ge;
    logic [WW-1:0] ws;
    logic [IW-1:0] we_idx;
    logic          len_zero, chk_err;
    logic [31:0]   mask;

    // Range check: granule bounds derived from the latched request.
    always_comb begin
        gs       = base_q[31:TSMAP_GRAN_SHIFT] - HeapBase[31:TSMAP_GRAN_SHIFT];
        len_gran = len_q[31:TSMAP_GRAN_SHIFT];
        end_sum  = {{(33-GW){1'b0}}, gs} + {{(33-GW){1'b0}}, len_gran};
        ge       = end_sum - 33'd1;
        ws       = gs[GW-1:TSMAP_WORD_SHIFT];
        we_idx   = ge[32:TSMAP_WORD_SHIFT];
        len_zero = (len_q == 32'd0);
        // End-of-range checks are meaningless for an empty range (ge underflows).
        chk_err  = (base_q[TSMAP_GRAN_SHIFT-1:0] != '0)
                 | (len_q[TSMAP_GRAN_SHIFT-1:0] != '0)
                 | (base_q < HeapBase)
                 | ((len_gran != '0) & (end_sum[32]
                                        | (we_idx >= MapWords)
                                        | ({{(IW-WW){1'b0}}, ws} >= MapWords)));
    end

    cheri_tsmap_mask_gen u_mask_gen (
        .first_i (cur_q == ws_q),
        .last_i  (cur_q == we_q),
        .bs_i    (bs_q),
        .be_i    (be_q),
        .mask_o  (mask)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid_i) state_d = CHK;
            CHK:  state_d = (chk_err || len_zero) ? RESP : WR;
            WR:   if (tsmap_gnt_i && (cur_q == we_q)) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            len_q  <= '0;
            set_q  <= 1'b0;
            err_q  <= 1'b0;
            ws_q   <= '0;
            we_q   <= '0;
            bs_q   <= '0;
            be_q   <= '0;
            cur_q  <= '0;
        end else begin
            if ((state_q == IDLE) && req_valid_i) begin
                base_q <= req_base_i;
                len_q  <= req_len_i;
                set_q  <= req_set_i;
            end
            // Word indices fit in 16 bits once the range has passed the size check.
            if (state_q == CHK) begin
                err_q <= chk_err;
                ws_q  <= ws[15:0];
                we_q  <= we_idx[15:0];
                bs_q  <= gs[TSMAP_WORD_SHIFT-1:0];
                be_q  <= ge[TSMAP_WORD_SHIFT-1:0];
                cur_q <= ws[15:0];
            end
            if ((state_q == WR) && tsmap_gnt_i && (cur_q != we_q)) begin
                cur_q <= cur_q + 16'd1;
            end
        end
    end

    always_comb begin
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        resp_err_o    = 1'b0;
        tsmap_cs_o    = 1'b0;
        tsmap_we_o    = 1'b0;
        tsmap_addr_o  = '0;
        tsmap_wdata_o = '0;
        tsmap_bmask_o = '0;
        unique case (state_q)
            IDLE: req_ready_o = 1'b1;
            WR: begin
                tsmap_cs_o    = 1'b1;
                tsmap_we_o    = 1'b1;
                tsmap_addr_o  = cur_q;
                tsmap_wdata_o = {32{set_q}};
                tsmap_bmask_o = mask;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cheri_tsmap_painter.sv
// Directed bench for the TSMAP painter: latency, masks, rejects, stalls,
// busy handling and asynchronous reset.
module tb_cheri_tsmap_painter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_base_i;
    logic [31:0] req_len_i;
    logic        req_set_i;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic        tsmap_cs_o;
    logic        tsmap_we_o;
    logic [15:0] tsmap_addr_o;
    logic [31:0] tsmap_wdata_o;
    logic [31:0] tsmap_bmask_o;
    logic        tsmap_gnt_i;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int resps  = 0;
    int snap;

    cheri_tsmap_painter #(
        .HeapBase  (32'h8000_0000),
        .TSMapSize (1024)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_base_i    (req_base_i),
        .req_len_i     (req_len_i),
        .req_set_i     (req_set_i),
        .resp_valid_o  (resp_valid_o),
        .resp_err_o    (resp_err_o),
        .tsmap_cs_o    (tsmap_cs_o),
        .tsmap_we_o    (tsmap_we_o),
        .tsmap_addr_o  (tsmap_addr_o),
        .tsmap_wdata_o (tsmap_wdata_o),
        .tsmap_bmask_o (tsmap_bmask_o),
        .tsmap_gnt_i   (tsmap_gnt_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (tsmap_cs_o && tsmap_gnt_i) writes <= writes + 1;
        if (resp_valid_o) resps <= resps + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns in cycle 1 (CHK) with valid dropped.
    task automatic send(input logic [31:0] base, input logic [31:0] len, input logic set);
        @(negedge clk_i);
        check("ready_before_req", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_base_i  = base;
        req_len_i   = len;
        req_set_i   = set;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("chk_no_cs", {31'd0, tsmap_cs_o}, 32'd0);
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic expect_wr(input string tag, input logic [15:0] addr,
                             input logic [31:0] mask, input logic [31:0] wdata);
        check({tag, "_cs"},    {31'd0, tsmap_cs_o},    32'd1);
        check({tag, "_we"},    {31'd0, tsmap_we_o},    32'd1);
        check({tag, "_addr"},  {16'd0, tsmap_addr_o},  {16'd0, addr});
        check({tag, "_mask"},  tsmap_bmask_o,          mask);
        check({tag, "_wdata"}, tsmap_wdata_o,          wdata);
        check({tag, "_ready"}, {31'd0, req_ready_o},   32'd0);
        check({tag, "_rv"},    {31'd0, resp_valid_o},  32'd0);
    endtask

    task automatic expect_resp(input string tag, input logic err);
        check({tag, "_rv"},    {31'd0, resp_valid_o}, 32'd1);
        check({tag, "_err"},   {31'd0, resp_err_o},   {31'd0, err});
        check({tag, "_cs"},    {31'd0, tsmap_cs_o},   32'd0);
        check({tag, "_ready"}, {31'd0, req_ready_o},  32'd0);
    endtask

    // Error or empty request: nothing written, response in cycle 2.
    task automatic short_case(input string tag, input logic [31:0] base,
                              input logic [31:0] len, input logic err);
        snap = writes;
        send(base, len, 1'b1);
        step();
        expect_resp(tag, err);
        check({tag, "_writes"}, writes - snap, 32'd0);
        step();
        check({tag, "_idle_ready"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_base_i  = '0;
        req_len_i   = '0;
        req_set_i   = 1'b0;
        tsmap_gnt_i = 1'b1;
        #3;
        check("rst_ready", {31'd0, req_ready_o},  32'd1);
        check("rst_rv",    {31'd0, resp_valid_o}, 32'd0);
        check("rst_err",   {31'd0, resp_err_o},   32'd0);
        check("rst_cs",    {31'd0, tsmap_cs_o},   32'd0);
        check("rst_we",    {31'd0, tsmap_we_o},   32'd0);
        check("rst_addr",  {16'd0, tsmap_addr_o}, 32'd0);
        check("rst_wdata", tsmap_wdata_o,         32'd0);
        check("rst_mask",  tsmap_bmask_o,         32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single granule, set
        snap = writes;
        send(32'h8000_0000, 32'd8, 1'b1);
        step();
        expect_wr("single", 16'd0, 32'h0000_0001, 32'hFFFF_FFFF);
        step();
        expect_resp("single_resp", 1'b0);
        check("single_writes", writes - snap, 32'd1);
        step();
        check("single_idle", {31'd0, req_ready_o}, 32'd1);

        // Three-word clear spanning a partial, full and partial word
        snap = writes;
        send(32'h8000_00F8, 32'h110, 1'b0);
        step();
        expect_wr("multi_w0", 16'd0, 32'h8000_0000, 32'h0);
        step();
        expect_wr("multi_w1", 16'd1, 32'hFFFF_FFFF, 32'h0);
        step();
        expect_wr("multi_w2", 16'd2, 32'h0000_0001, 32'h0);
        step();
        expect_resp("multi_resp", 1'b0);
        check("multi_writes", writes - snap, 32'd3);

        // Rejects and zero length
        short_case("rej_misalign", 32'h8000_0004, 32'd8, 1'b1);
        short_case("rej_word1024", 32'h8004_0000, 32'd8, 1'b1);
        short_case("rej_below",    32'h7FFF_FFF8, 32'd8, 1'b1);
        short_case("rej_hugelen",  32'h8000_0000, 32'hFFFF_FFF8, 1'b1);
        short_case("rej_lenalign", 32'h8000_0000, 32'd12, 1'b1);
        short_case("zero_len",     32'h8000_0000, 32'd0, 1'b0);
        short_case("last_word_ok", 32'h8003_FFF8, 32'd0, 1'b0);

        // Last granule of the map is accepted
        snap = writes;
        send(32'h8003_FFF8, 32'd8, 1'b1);
        step();
        expect_wr("lastgran", 16'd1023, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        expect_resp("lastgran_resp", 1'b0);
        check("lastgran_writes", writes - snap, 32'd1);

        // Arbitration stall of three cycles on word 1
        snap = writes;
        send(32'h8000_00F8, 32'h110, 1'b0);
        step();
        expect_wr("stall_w0", 16'd0, 32'h8000_0000, 32'h0);
        step();
        expect_wr("stall_w1a", 16'd1, 32'hFFFF_FFFF, 32'h0);
        tsmap_gnt_i = 1'b0;
        step();
        expect_wr("stall_w1b", 16'd1, 32'hFFFF_FFFF, 32'h0);
        step();
        expect_wr("stall_w1c", 16'd1, 32'hFFFF_FFFF, 32'h0);
        step();
        expect_wr("stall_w1d", 16'd1, 32'hFFFF_FFFF, 32'h0);
        tsmap_gnt_i = 1'b1;
        step();
        expect_wr("stall_w2", 16'd2, 32'h0000_0001, 32'h0);
        step();
        expect_resp("stall_resp", 1'b0);
        check("stall_writes", writes - snap, 32'd3);

        // Second request held while busy is taken only after RESP
        snap = writes;
        send(32'h8000_00F8, 32'h110, 1'b1);
        req_valid_i = 1'b1;
        req_base_i  = 32'h8000_0010;
        req_len_i   = 32'd8;
        req_set_i   = 1'b1;
        step();
        expect_wr("busy_w0", 16'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        expect_wr("busy_w1", 16'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        expect_wr("busy_w2", 16'd2, 32'h0000_0001, 32'hFFFF_FFFF);
        step();
        expect_resp("busy_resp1", 1'b0);
        step();
        check("busy_ready_idle", {31'd0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
        check("busy_chk_ready", {31'd0, req_ready_o}, 32'd0);
        check("busy_chk_cs", {31'd0, tsmap_cs_o}, 32'd0);
        step();
        expect_wr("busy_second", 16'd0, 32'h0000_0004, 32'hFFFF_FFFF);
        step();
        expect_resp("busy_resp2", 1'b0);
        check("busy_writes", writes - snap, 32'd4);
        step();

        // Asynchronous reset during word 1
        send(32'h8000_00F8, 32'h110, 1'b1);
        step();
        expect_wr("rstwr_w0", 16'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        expect_wr("rstwr_w1", 16'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_ready", {31'd0, req_ready_o},  32'd1);
        check("arst_cs",    {31'd0, tsmap_cs_o},   32'd0);
        check("arst_we",    {31'd0, tsmap_we_o},   32'd0);
        check("arst_addr",  {16'd0, tsmap_addr_o}, 32'd0);
        check("arst_wdata", tsmap_wdata_o,         32'd0);
        check("arst_mask",  tsmap_bmask_o,         32'd0);
        check("arst_rv",    {31'd0, resp_valid_o}, 32'd0);
        snap = resps;
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_rv", {31'd0, resp_valid_o}, 32'd0);
            check("post_rst_cs", {31'd0, tsmap_cs_o}, 32'd0);
        end
        check("post_rst_resps", resps - snap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
